// File: rtl/mem_io_ctrl_pkg.sv
// Shared constants for the data-memory / memory-mapped IO controller.
package mem_io_pkg;

  localparam logic [31:0] LED_ADDR_DEF = 32'hFFFFFC60;
  localparam logic [31:0] SEG_ADDR_DEF = 32'hFFFFFC00;
  localparam logic [31:0] SW_ADDR_DEF  = 32'hFFFFFC70;

  // IO lives in the top 1 KiB of the address space: bits [31:10] all set.
  localparam logic [31:0] IO_MASK = 32'hFFFFFC00;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RD_WAIT = 2'd1;
  localparam logic [1:0] S_RD_DONE = 2'd2;

  function automatic logic is_io_addr(input logic [31:0] addr);
    return (addr & IO_MASK) == IO_MASK;
  endfunction

endpackage

// File: rtl/mem_io_ctrl_sync2.sv
// 16-bit two-flop synchronizer for the raw switch inputs.
module sync2 (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] d_in,
  output logic [15:0] q_out
);

  logic [15:0] meta_q, meta_d;
  logic [15:0] sync_q, sync_d;

  always_comb begin
    meta_d = d_in;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q_out = sync_q;

endmodule

// File: rtl/mem_io_ctrl.sv
// Routes CPU loads/stores to BRAM or IO registers, stalls for BRAM read
// latency, and gives the UART loader priority on the BRAM port.
module mem_io_ctrl
  import mem_io_pkg::*;
#(
  parameter int          MEM_RD_LAT = 1,
  parameter int          MEM_AW     = 14,
  parameter logic [31:0] LED_ADDR   = LED_ADDR_DEF,
  parameter logic [31:0] SEG_ADDR   = SEG_ADDR_DEF,
  parameter logic [31:0] SW_ADDR    = SW_ADDR_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_stall,
  input  logic              ldr_req,
  input  logic [MEM_AW-1:0] ldr_addr,
  input  logic [31:0]       ldr_wdata,
  output logic              ldr_gnt,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic [15:0]       sw_in,
  output logic [15:0]       led_out,
  output logic [31:0]       seg_out
);

  localparam logic [1:0] RD_LAT = MEM_RD_LAT[1:0];

  logic [1:0]  state_q, state_d;
  logic [1:0]  rd_cnt_q, rd_cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic [15:0] led_q, led_d;
  logic [31:0] seg_q, seg_d;
  logic [15:0] sw_sync;
  logic        is_io;
  logic        unused_addr_bits;

  sync2 u_sw_sync (
    .clk   (clk),
    .rst   (rst),
    .d_in  (sw_in),
    .q_out (sw_sync)
  );

  assign is_io            = is_io_addr(cpu_addr);
  assign unused_addr_bits = ^cpu_addr[1:0];

  always_comb begin
    state_d   = state_q;
    rd_cnt_d  = rd_cnt_q;
    rdata_d   = rdata_q;
    led_d     = led_q;
    seg_d     = seg_q;
    mem_addr  = cpu_addr[MEM_AW+1:2];
    mem_we    = 1'b0;
    mem_wdata = cpu_wdata;
    ldr_gnt   = 1'b0;
    cpu_stall = 1'b0;
    cpu_rdata = '0;
    case (state_q)
      S_IDLE: begin
        // Loader owns the port this cycle; any CPU access is held off and retried.
        if (ldr_req) begin
          mem_addr  = ldr_addr;
          mem_we    = 1'b1;
          mem_wdata = ldr_wdata;
          ldr_gnt   = 1'b1;
          cpu_stall = cpu_req;
        end else if (cpu_req) begin
          if (is_io) begin
            if (cpu_we) begin
              if (cpu_addr == LED_ADDR)      led_d = cpu_wdata[15:0];
              else if (cpu_addr == SEG_ADDR) seg_d = cpu_wdata;
            end else if (cpu_addr == SW_ADDR) begin
              cpu_rdata = {16'b0, sw_sync};
            end
          end else if (cpu_we) begin
            mem_we = 1'b1;
          end else begin
            cpu_stall = 1'b1;
            rd_cnt_d  = 2'd1;
            state_d   = S_RD_WAIT;
          end
        end
      end
      S_RD_WAIT: begin
        cpu_stall = 1'b1;
        if (rd_cnt_q == RD_LAT) begin
          rdata_d = mem_rdata;
          state_d = S_RD_DONE;
        end else begin
          rd_cnt_d = rd_cnt_q + 2'd1;
        end
      end
      S_RD_DONE: begin
        cpu_rdata = rdata_q;
        rd_cnt_d  = 2'd0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rd_cnt_q <= 2'd0;
      rdata_q  <= '0;
      led_q    <= '0;
      seg_q    <= '0;
    end else begin
      state_q  <= state_d;
      rd_cnt_q <= rd_cnt_d;
      rdata_q  <= rdata_d;
      led_q    <= led_d;
      seg_q    <= seg_d;
    end
  end

  assign led_out = led_q;
  assign seg_out = seg_q;

endmodule

// File: tb/tb_mem_io_ctrl.sv
// Directed bench for mem_io_ctrl with a one-cycle-latency BRAM model.
module tb_mem_io_ctrl;

  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we;
  logic [31:0]   cpu_addr, cpu_wdata, cpu_rdata;
  logic          cpu_stall;
  logic          ldr_req;
  logic [AW-1:0] ldr_addr;
  logic [31:0]   ldr_wdata;
  logic          ldr_gnt;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [31:0]   mem_wdata, mem_rdata;
  logic [15:0]   sw_in, led_out;
  logic [31:0]   seg_out;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] bram [0:1023];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    mem_rdata <= bram[mem_addr[9:0]];
    if (mem_we) bram[mem_addr[9:0]] <= mem_wdata;
  end

  mem_io_ctrl #(.MEM_RD_LAT(1), .MEM_AW(AW)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ldr_req(ldr_req), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata), .ldr_gnt(ldr_gnt),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .sw_in(sw_in), .led_out(led_out), .seg_out(seg_out)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
    cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) bram[i] = '0;
    mem_rdata = '0;
    rst = 1'b1;
    cpu(0, 0, 32'h0, 32'h0);
    ldr_req = 0; ldr_addr = '0; ldr_wdata = '0; sw_in = '0;
    #12;
    chk("rst_led", {16'b0, led_out}, 32'h0);
    chk("rst_seg", seg_out, 32'h0);
    chk("rst_stall", {31'b0, cpu_stall}, 32'h0);
    chk("rst_we", {31'b0, mem_we}, 32'h0);
    chk("rst_gnt", {31'b0, ldr_gnt}, 32'h0);
    chk("rst_rdata", cpu_rdata, 32'h0);
    @(negedge clk); rst = 1'b0;

    // LED / seven-segment / unmapped IO stores
    step(); cpu(1, 1, 32'hFFFFFC60, 32'h0000ABCD); #1;
    chk("led_st_stall", {31'b0, cpu_stall}, 32'h0);
    chk("led_st_we", {31'b0, mem_we}, 32'h0);
    step(); chk("led_val", {16'b0, led_out}, 32'h0000ABCD);
    cpu(1, 1, 32'hFFFFFC00, 32'h12345678); #1;
    chk("seg_st_stall", {31'b0, cpu_stall}, 32'h0);
    step(); chk("seg_val", seg_out, 32'h12345678);
    cpu(1, 1, 32'hFFFFFC44, 32'h00005555);
    step(); chk("unmapped_st_led", {16'b0, led_out}, 32'h0000ABCD);
    chk("unmapped_st_seg", seg_out, 32'h12345678);

    // Switch read through the 2-flop synchronizer
    sw_in = 16'h1234; cpu(1, 0, 32'hFFFFFC70, 32'h0); #1;
    chk("sw_lat0", cpu_rdata, 32'h0);
    step(); chk("sw_lat1", cpu_rdata, 32'h0);
    step(); chk("sw_lat2", cpu_rdata, 32'h00001234);
    step(); chk("sw_rd", cpu_rdata, 32'h00001234);
    chk("sw_stall", {31'b0, cpu_stall}, 32'h0);

    // Memory store then load
    cpu(1, 1, 32'h00000010, 32'hDEADBEEF); #1;
    chk("mst_we", {31'b0, mem_we}, 32'h1);
    chk("mst_addr", {18'b0, mem_addr}, 32'h4);
    chk("mst_data", mem_wdata, 32'hDEADBEEF);
    chk("mst_stall", {31'b0, cpu_stall}, 32'h0);
    step(); cpu(1, 0, 32'h00000010, 32'h0); #1;
    chk("ld_idle_stall", {31'b0, cpu_stall}, 32'h1);
    chk("ld_idle_addr", {18'b0, mem_addr}, 32'h4);
    chk("ld_idle_rdata", cpu_rdata, 32'h0);
    step(); chk("ld_wait_stall", {31'b0, cpu_stall}, 32'h1);
    chk("ld_wait_we", {31'b0, mem_we}, 32'h0);
    step(); chk("ld_done_stall", {31'b0, cpu_stall}, 32'h0);
    chk("ld_done_rdata", cpu_rdata, 32'hDEADBEEF);
    cpu(0, 0, 32'h0, 32'h0);
    step(); chk("ld_after_rdata", cpu_rdata, 32'h0);

    // Loader beats a simultaneous CPU store
    ldr_req = 1; ldr_addr = 14'd7; ldr_wdata = 32'hCAFEF00D;
    cpu(1, 1, 32'h00000020, 32'h11111111); #1;
    chk("arb_gnt", {31'b0, ldr_gnt}, 32'h1);
    chk("arb_we", {31'b0, mem_we}, 32'h1);
    chk("arb_addr", {18'b0, mem_addr}, 32'h7);
    chk("arb_data", mem_wdata, 32'hCAFEF00D);
    chk("arb_stall", {31'b0, cpu_stall}, 32'h1);
    step(); ldr_req = 0; #1;
    chk("retry_gnt", {31'b0, ldr_gnt}, 32'h0);
    chk("retry_we", {31'b0, mem_we}, 32'h1);
    chk("retry_addr", {18'b0, mem_addr}, 32'h8);
    chk("retry_data", mem_wdata, 32'h11111111);
    chk("retry_stall", {31'b0, cpu_stall}, 32'h0);

    // Loader request during a read waits for IDLE
    step(); cpu(1, 0, 32'h00000010, 32'h0);
    step(); ldr_req = 1; ldr_addr = 14'd9; ldr_wdata = 32'h00000055; #1;
    chk("ldw_wait_gnt", {31'b0, ldr_gnt}, 32'h0);
    chk("ldw_wait_we", {31'b0, mem_we}, 32'h0);
    chk("ldw_wait_stall", {31'b0, cpu_stall}, 32'h1);
    step(); chk("ldw_done_gnt", {31'b0, ldr_gnt}, 32'h0);
    chk("ldw_done_we", {31'b0, mem_we}, 32'h0);
    chk("ldw_done_rdata", cpu_rdata, 32'hDEADBEEF);
    cpu(0, 0, 32'h0, 32'h0);
    step(); chk("ldw_idle_gnt", {31'b0, ldr_gnt}, 32'h1);
    chk("ldw_idle_addr", {18'b0, mem_addr}, 32'h9);
    ldr_req = 0;

    // Reset in the middle of a read
    step(); cpu(1, 0, 32'h00000010, 32'h0);
    step(); chk("rstrd_pre_stall", {31'b0, cpu_stall}, 32'h1);
    rst = 1'b1; cpu(0, 0, 32'h0, 32'h0); #1;
    chk("rstrd_stall", {31'b0, cpu_stall}, 32'h0);
    chk("rstrd_led", {16'b0, led_out}, 32'h0);
    chk("rstrd_seg", seg_out, 32'h0);
    step(); rst = 1'b0;
    step(); cpu(1, 0, 32'hFFFFFC44, 32'h0); #1;
    chk("unmapped_ld", cpu_rdata, 32'h0);
    chk("unmapped_ld_stall", {31'b0, cpu_stall}, 32'h0);
    step(); cpu(0, 0, 32'h0, 32'h0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
